// File: rtl/schoolbook_digit.sv
// schoolbook_digit: digit-serial unsigned multiplier, c = a * b, with a start/done handshake.
// Define SCHOOLBOOK_DIGIT_EARLY_EXIT_EN to finish as soon as the remaining b digits are zero.
module schoolbook_digit #(
  parameter int A_W = 409,
  parameter int B_W = 409,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] c
);
  localparam int NDIG = (B_W + DIGIT - 1) / DIGIT;
  localparam int PB_W = NDIG * DIGIT;
  localparam int P_W = A_W + B_W;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [A_W-1:0] a_reg;
  logic [PB_W-1:0] b_reg;
  logic [P_W-1:0] acc, acc_d;
  logic [KW-1:0] k;
  logic [A_W+DIGIT-1:0] pp;
  logic load, last;
  int shamt;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    pp = (A_W+DIGIT)'(a_reg) * (A_W+DIGIT)'(b_reg[DIGIT-1:0]);
    shamt = int'(k) * DIGIT;
    acc_d = acc + (P_W'(pp) << shamt);
`ifdef SCHOOLBOOK_DIGIT_EARLY_EXIT_EN
    last = k == K_LAST || (b_reg >> DIGIT) == '0;
`else
    last = k == K_LAST;
`endif
    load = start && state != RUN;
    state_d = load ? RUN : state != RUN ? IDLE : last ? DONE : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc <= '0;
      k <= '0;
      c <= '0;
    end else if (load) begin
      a_reg <= a;
      b_reg <= PB_W'(b);
      acc <= '0;
      k <= '0;
    end else if (state == RUN) begin
      acc <= acc_d;
      b_reg <= b_reg >> DIGIT;
      k <= k + KW'(1);
      if (last) c <= acc_d;
    end
endmodule

// File: tb/tb_schoolbook_digit.sv
// tb_schoolbook_digit: scoreboard bench for schoolbook_digit (default parameters plus DIGIT=1/7/409 instances).
module tb_schoolbook_digit;
  localparam int W = 409;
  localparam int NDIG = 103;
  typedef struct {logic [2*W-1:0] p; int due;} exp_t;
  logic clk = 0, rst, start;
  logic [W-1:0] a, b;
  logic busy, done, busy1, done1, busy7, done7, busy409, done409;
  logic [2*W-1:0] c, c1, c7, c409;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, m_left = 0, rst_cnt = 0, seen_rst = 0;
  logic [2*W-1:0] m_c = '0;
  always #5 clk = ~clk;
  schoolbook_digit u_dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy), .done(done), .c(c));
  schoolbook_digit #(.DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy1), .done(done1), .c(c1));
  schoolbook_digit #(.DIGIT(7)) u_d7 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy7), .done(done7), .c(c7));
  schoolbook_digit #(.DIGIT(409)) u_d409 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy409), .done(done409), .c(c409));

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int runs_for(input logic [W-1:0] bb);
`ifdef SCHOOLBOOK_DIGIT_EARLY_EXIT_EN
    int r = 1;
    logic [W-1:0] bv;
    for (int i = 0; i < NDIG; i++) begin
      bv = bb >> (4 * i);
      if (bv[3:0] != 4'd0) r = i + 1;
    end
    return r;
`else
    return NDIG;
`endif
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 13; i++) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  always @(posedge rst) rst_cnt++;

  // Checks outputs of the edge just taken, then predicts the coming edge.
  always @(negedge clk) begin
    logic exp_done;
    if (rst || rst_cnt != seen_rst) begin
      seen_rst = rst_cnt;
      q.delete();
      m_left = 0;
      m_c = '0;
    end
    check("busy", {817'b0, busy}, {817'b0, m_left > 0});
    exp_done = q.size() > 0 && q[0].due == cyc;
    check("done", {817'b0, done}, {817'b0, exp_done});
    if (exp_done) begin
      m_c = q[0].p;
      void'(q.pop_front());
    end
    check("c", c, m_c);
    if (!rst) begin
      cyc++;
      if (m_left == 0 && start) begin
        m_left = runs_for(b);
        q.push_back('{p: {{W{1'b0}}, a} * {{W{1'b0}}, b}, due: cyc + m_left});
      end else if (m_left > 0) m_left--;
    end
  end

  task automatic wait_idle();
    logic idle = 0;
    for (int i = 0; i < 700 && !idle; i++) begin
      @(posedge clk);
      idle = m_left == 0 && q.size() == 0;
    end
    check("idle_timeout", {817'b0, idle}, {817'b0, 1'b1});
  endtask

  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb);
    #1 a = aa;
    b = bb;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_idle();
  endtask

  initial begin
    #3000000 $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ones, hi;
    logic [2*W-1:0] pones;
    int d1, d7, d409;
    ones = '1;
    hi = '0;
    hi[W-1] = 1'b1;
    pones = '0;
    pones = pones - ({{(2*W-1){1'b0}}, 1'b1} << 410) + 1;
    rst = 1; start = 0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1 check("rst_c", c, '0);
    check("rst_busy", {817'b0, busy}, '0);
    check("rst_done", {817'b0, done}, '0);
    // all-ones operands on every digit width at once
    a = ones; b = ones; start = 1;
    @(posedge clk);
    #1 start = 0;
    d1 = -1; d7 = -1; d409 = -1;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_alt", {815'b0, busy1, busy7, busy409}, {815'b0, 3'b111});
      if (done1) begin d1 = i; check("c_d1", c1, pones); end
      if (done7) begin d7 = i; check("c_d7", c7, pones); end
      if (done409) begin d409 = i; check("c_d409", c409, pones); end
    end
    check("lat_d1", 818'(d1), 818'(409));
    check("lat_d7", 818'(d7), 818'(59));
    check("lat_d409", 818'(d409), 818'(1));
    check("c_ones", c, pones);
    wait_idle();
    op(3, 5);
    check("c_3x5", c, 818'(15));
    op(rnd(), 0);
    op(rnd(), 256);
    op(rnd(), hi);
    // start during RUN is ignored
    #1 a = 11; b = hi | 13; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(posedge clk);
    #1 a = 100; b = 200; start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_idle();
    // start held through DONE: back-to-back
    #1 a = rnd(); b = rnd() | hi; start = 1;
    @(posedge clk);
    #1 a = rnd(); b = rnd();
    repeat (105) @(posedge clk);
    #1 start = 0;
    wait_idle();
    // reset mid-RUN
    #1 a = rnd(); b = hi; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (49) @(posedge clk);
    #3 rst = 1;
    #1 check("mid_rst_busy", {817'b0, busy}, '0);
    check("mid_rst_done", {817'b0, done}, '0);
    check("mid_rst_c", c, '0);
    @(posedge clk);
    #1 rst = 0;
    op(7, 9);
    check("c_7x9", c, 818'(63));
    // random back-to-back traffic with occasional reset pulses
    for (int n = 0; n < 30000; n++) begin
      @(posedge clk);
      #1 start = $urandom_range(0, 3) == 0;
      a = rnd();
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = rnd() & W'(32'hffff);
        default: b = rnd();
      endcase
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
    end
    #1 start = 0;
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
